// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared types and constants for the sequential shift-and-add multiplier.
//   state_t      : controller states (2-bit)
//   ALU_*        : opcodes of the shared alu datapath
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADD   = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational N-bit ALU shared by the multiplier controller.
// Ports:
//   i_a, i_b     : N-bit operands
//   i_ctrl       : 00 add, 01 sub (a - b), 10 and, 11 or
//   o_result     : N-bit result
//   o_carry_out  : carry of add; no-borrow flag of sub; 0 for logic ops
// -----------------------------------------------------------------------------
module alu
    import alu_mul_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_ctrl,
    output logic [N-1:0] o_result,
    output logic         o_carry_out
);

    always_comb begin
        o_result    = '0;
        o_carry_out = 1'b0;
        case (i_ctrl)
            ALU_ADD: {o_carry_out, o_result} = {1'b0, i_a} + {1'b0, i_b};
            ALU_SUB: {o_carry_out, o_result} = {1'b0, i_a} + {1'b0, ~i_b} + (N+1)'(1);
            ALU_AND: o_result = i_a & i_b;
            default: o_result = i_a | i_b;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle unsigned N x N -> 2N shift-and-add multiplier. One shared alu
// (always ADD) accumulates the multiplicand into the high half; the low half
// starts as the multiplier and is shifted out while product bits shift in.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset    : asynchronous, active-high reset
//   i_start    : request, sampled only in IDLE
//   i_a, i_b   : multiplicand / multiplier, captured on accepted start
//   o_busy     : high in every state except IDLE
//   o_done     : one-cycle pulse in DONE
//   o_product  : {hi, lo}, valid from DONE, held until next accepted start
// Build option:
//   ALU_MUL_SEQ_SKIP_ZERO_EN : when defined, a zero multiplier bit skips the
//   ALU cycle and shifts directly in ADD (latency N + popcount(b)).
// -----------------------------------------------------------------------------
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic          r_carry;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_alu_b;
    logic [N-1:0]  w_alu_res;
    logic          w_alu_co;
    logic          w_last;
    logic          w_skip;

    assign w_alu_b = r_lo[0] ? r_mcand : '0;
    // cnt + 1 == N, evaluated before the increment
    assign w_last  = (r_cnt == LAST_CNT);

`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
    assign w_skip = ~r_lo[0];
`else
    assign w_skip = 1'b0;
`endif

    alu #(.N(N)) m_alu (
        .i_a         (r_hi),
        .i_b         (w_alu_b),
        .i_ctrl      (ALU_ADD),
        .o_result    (w_alu_res),
        .o_carry_out (w_alu_co)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = ADD;
            ADD:     if (w_skip) w_next = w_last ? DONE : ADD;
                     else        w_next = SHIFT;
            SHIFT:   w_next = w_last ? DONE : ADD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_lo    <= i_b;
                        r_hi    <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    if (w_skip) begin
                        // carry is always 0 here (cleared by the previous shift)
                        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[N-1:1]};
                        r_cnt        <= r_cnt + CW'(1);
                    end else begin
                        r_hi    <= w_alu_res;
                        r_carry <= w_alu_co;
                    end
                end
                SHIFT: begin
                    // ADD carry re-enters at the top so it is never lost
                    {r_carry, r_hi, r_lo} <= {1'b0, r_carry, r_hi, r_lo[N-1:1]};
                    r_cnt                 <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);
    assign o_product = {r_hi, r_lo};

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.N(N)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (busy),
        .o_done    (done),
        .o_product (product)
    );

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Edges from accept to DONE entry, from the cycle-count rules alone.
    function automatic int exp_latency(input logic [N-1:0] mb);
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
        return N + $countones(mb);
`else
        return 2 * N;
`endif
    endfunction

    // Start a multiply, optionally re-pulse start while busy, and check result,
    // latency, busy, single done pulse and product hold.
    task automatic run_mul(input string tag, input logic [N-1:0] ma, input logic [N-1:0] mb,
                           input logic [2*N-1:0] exp_p, input int glitch_at);
        int edges   = 0;
        bit got     = 0;
        bit busy_ok = 1;
        @(negedge clk);
        a = ma; b = mb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        if (!busy) busy_ok = 0;
        while (edges < 100 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) got = 1;
            else if (!busy) busy_ok = 0;
            if (edges == glitch_at) begin
                start = 1'b1; a = 8'h10; b = 8'h10;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(edges), 32'(exp_latency(mb)));
        chk({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
        chk({tag, " product"}, 32'(product), 32'(exp_p));
        @(negedge clk);
        chk({tag, " done_single"}, 32'(done), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, " product_held"}, 32'(product), 32'(exp_p));
        chk({tag, " no_extra_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{a: 8'h00, b: 8'h00, p: 16'h0000};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        vecs[2] = '{a: 8'hBD, b: 8'hA5, p: 16'h79D1};
        vecs[3] = '{a: 8'h0D, b: 8'hFF, p: 16'h0CF3};
        vecs[4] = '{a: 8'h01, b: 8'h80, p: 16'h0080};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset product", 32'(product), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, -1);

        // start while busy must be ignored
        run_mul("busy_start", 8'h03, 8'h05, 16'h000F, 5);
        run_mul("fresh_start", 8'h10, 8'h10, 16'h0100, -1);

        // reset in mid-operation
        @(negedge clk);
        a = 8'h0D; b = 8'h0B; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_mul("after_reset", 8'h0D, 8'h0B, 16'h008F, -1);

        // randomized against plain multiplication
        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = N'($urandom);
            run_mul($sformatf("rand%0d", i), ra, rb, (2*N)'(ra) * (2*N)'(rb), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
